// File: rtl/bp_pht_updater.sv
// bp_pht_updater: trains the gshare PHT from resolved branch outcomes.
//
// Resolved branches are converted at enqueue into {index, new 2-bit counter}
// and parked in a small FIFO. The FIFO drains into the PHT write port whenever
// fetch is not holding it. After reset, every PHT entry is first written with
// INIT_VALUE; updates are accepted only once that pass completes.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   upd_valid      resolved-branch update offered
//   upd_ready      update accepted this cycle (RUN and FIFO not full)
//   upd_pc         branch PC (bits [PHT_INDEX_WIDTH+1:2] form the index)
//   upd_ghr        global history snapshot taken at prediction
//   upd_taken      resolved direction
//   upd_prev_ctr   PHT counter value read at prediction
//   pht_wr_stall   fetch owns the PHT port this cycle; no write
//   pht_we         PHT write enable
//   pht_waddr      PHT write index
//   pht_wdata      PHT write data
//   init_busy      initialisation pass in progress
//   occupancy      number of queued updates
//
// Build option:
//   BP_PHT_UPDATE_FORWARD_EN  when defined, the base counter for a new update
//   is taken from the youngest queued entry with the same index (so
//   back-to-back updates to one index accumulate); otherwise upd_prev_ctr.

module bp_pht_updater #(
    parameter int           PC_WIDTH        = 32,
    parameter int           PHT_INDEX_WIDTH = 10,
    parameter int           GHR_WIDTH       = 10,
    parameter int           QUEUE_DEPTH     = 4,
    parameter logic [1:0]   INIT_VALUE      = 2'b01
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               upd_valid,
    output logic                               upd_ready,
    input  logic [PC_WIDTH-1:0]                upd_pc,
    input  logic [GHR_WIDTH-1:0]               upd_ghr,
    input  logic                               upd_taken,
    input  logic [1:0]                         upd_prev_ctr,
    input  logic                               pht_wr_stall,
    output logic                               pht_we,
    output logic [PHT_INDEX_WIDTH-1:0]         pht_waddr,
    output logic [1:0]                         pht_wdata,
    output logic                               init_busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   occupancy
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int PW = $clog2(QUEUE_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [PHT_INDEX_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;

    logic [PHT_INDEX_WIDTH-1:0] fifo_idx_q [QUEUE_DEPTH];
    logic [1:0]                 fifo_ctr_q [QUEUE_DEPTH];

    logic                       in_init, in_run, init_we, full, empty, enq, deq;
    logic [PHT_INDEX_WIDTH-1:0] upd_idx, head_idx;
    logic [1:0]                 head_ctr, base_ctr, new_ctr;
    logic                       unused_pc;

    assign unused_pc = ^{upd_pc[PC_WIDTH-1:PHT_INDEX_WIDTH+2], upd_pc[1:0]};

    assign in_init  = (state_q == ST_INIT);
    assign in_run   = (state_q == ST_RUN);
    assign init_we  = in_init & ~pht_wr_stall;
    assign full     = (count_q == CW'(QUEUE_DEPTH));
    assign empty    = (count_q == '0);
    assign head_idx = fifo_idx_q[rd_ptr_q];
    assign head_ctr = fifo_ctr_q[rd_ptr_q];

    // Full blocks enqueue even when the head drains in the same cycle.
    assign upd_ready = in_run & ~full;
    assign enq       = upd_valid & upd_ready;
    assign deq       = in_run & ~empty & ~pht_wr_stall;

    assign upd_idx = upd_pc[PHT_INDEX_WIDTH+1:2] ^ PHT_INDEX_WIDTH'(upd_ghr);

`ifdef BP_PHT_UPDATE_FORWARD_EN
    // Walk queued entries oldest to youngest so the youngest match wins; the
    // head is included even if it is being written this cycle.
    always_comb begin
        base_ctr = upd_prev_ctr;
        for (int i = 0; i < QUEUE_DEPTH; i++)
            if (CW'(i) < count_q && fifo_idx_q[rd_ptr_q + PW'(i)] == upd_idx)
                base_ctr = fifo_ctr_q[rd_ptr_q + PW'(i)];
    end
`else
    assign base_ctr = upd_prev_ctr;
`endif

    assign new_ctr = upd_taken ? ((base_ctr == 2'd3) ? 2'd3 : base_ctr + 2'd1)
                               : ((base_ctr == 2'd0) ? 2'd0 : base_ctr - 2'd1);

    always_comb begin
        pht_we    = in_init ? ~pht_wr_stall : deq;
        pht_waddr = in_init ? init_cnt_q : (empty ? '0 : head_idx);
        pht_wdata = in_init ? INIT_VALUE : (empty ? 2'd0 : head_ctr);
        init_busy = ~in_run;
        occupancy = count_q;
    end

    // IDLE and the unused encoding both fall into INIT.
    always_comb begin
        state_d    = in_init ? ((init_we && &init_cnt_q) ? ST_RUN : ST_INIT)
                             : (in_run ? ST_RUN : ST_INIT);
        init_cnt_d = init_we ? init_cnt_q + 1'b1 : init_cnt_q;
        wr_ptr_d   = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(enq) - CW'(deq);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            init_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_idx_q[wr_ptr_q] <= upd_idx;
            fifo_ctr_q[wr_ptr_q] <= new_ctr;
        end
    end

endmodule

// File: tb/tb_bp_pht_updater.sv
// tb_bp_pht_updater: scoreboard bench for bp_pht_updater.
module tb_bp_pht_updater;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [9:0]  upd_ghr;
    logic        upd_taken;
    logic [1:0]  upd_prev_ctr;
    logic        pht_wr_stall;
    logic        pht_we;
    logic [9:0]  pht_waddr;
    logic [1:0]  pht_wdata;
    logic        init_busy;
    logic [2:0]  occupancy;

    int n_vec = 0;
    int n_err = 0;
    logic [11:0] sb [$];

    bp_pht_updater dut (
        .clk(clk), .rst_n(rst_n),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_ghr(upd_ghr), .upd_taken(upd_taken), .upd_prev_ctr(upd_prev_ctr),
        .pht_wr_stall(pht_wr_stall), .pht_we(pht_we), .pht_waddr(pht_waddr),
        .pht_wdata(pht_wdata), .init_busy(init_busy), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {index, counter} for an accepted update.
    function automatic logic [11:0] model(input logic [31:0] pc, input logic [9:0] ghr,
                                          input logic tk, input logic [1:0] prev);
        logic [9:0] idx;
        logic [1:0] b;
        idx = pc[11:2] ^ ghr;
        b = prev;
`ifdef BP_PHT_UPDATE_FORWARD_EN
        foreach (sb[i]) if (sb[i][11:2] == idx) b = sb[i][1:0];
`endif
        if (tk) b = (b == 2'd3) ? b : b + 2'd1;
        else    b = (b == 2'd0) ? b : b - 2'd1;
        return {idx, b};
    endfunction

    always @(negedge clk) begin
        if (pht_we) begin
            if (sb.size() == 0) check("spurious_we", 32'(pht_we), 32'd0);
            else check("pht_write", 32'({pht_waddr, pht_wdata}), 32'(sb.pop_front()));
        end
    end

    task automatic push_init();
        for (int a = 0; a < 1024; a++) sb.push_back({10'(a), 2'b01});
    endtask

    task automatic run_init(input bit do_stall);
        int n;
        bit stalled;
        n = 0;
        stalled = 0;
        #1;
        check("idle_we", 32'(pht_we), 32'd0);
        check("idle_busy", 32'(init_busy), 32'd1);
        while (init_busy && n < 3000) begin
            if (do_stall && !stalled && pht_waddr == 10'd5) begin
                pht_wr_stall = 1'b1;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    check("stall_we", 32'(pht_we), 32'd0);
                    check("stall_addr", 32'(pht_waddr), 32'd5);
                    tick();
                    n++;
                end
                pht_wr_stall = 1'b0;
                stalled = 1;
            end else begin
                tick();
                n++;
            end
        end
        check("init_cycles", n, do_stall ? 32'd1028 : 32'd1025);
        check("init_left", sb.size(), 32'd0);
        check("ready_after_init", 32'(upd_ready), 32'd1);
        check("occ_after_init", 32'(occupancy), 32'd0);
    endtask

    task automatic offer(input logic [31:0] pc, input logic [9:0] ghr, input logic tk,
                         input logic [1:0] prev, input bit unstall);
        bit done;
        logic exp_rdy;
        done = 0;
        upd_valid = 1'b1;
        upd_pc = pc;
        upd_ghr = ghr;
        upd_taken = tk;
        upd_prev_ctr = prev;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            exp_rdy = sb.size() < QD;
            check("upd_ready", 32'(upd_ready), 32'(exp_rdy));
            check("occupancy", 32'(occupancy), sb.size());
            if (exp_rdy) begin
                sb.push_back(model(pc, ghr, tk, prev));
                done = 1;
            end else if (unstall) pht_wr_stall = 1'b0;
            tick();
        end
        upd_valid = 1'b0;
        check("offer_done", 32'(done), 32'd1);
    endtask

    task automatic drain();
        pht_wr_stall = 1'b0;
        for (int k = 0; k < 50 && sb.size() != 0; k++) tick();
        #1;
        check("drain_left", sb.size(), 32'd0);
        check("drain_occ", 32'(occupancy), 32'd0);
        check("drain_ready", 32'(upd_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        upd_valid = 1'b0;
        upd_pc = '0;
        upd_ghr = '0;
        upd_taken = 1'b0;
        upd_prev_ctr = '0;
        pht_wr_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 32'(pht_we), 32'd0);
        check("rst_addr", 32'(pht_waddr), 32'd0);
        check("rst_data", 32'(pht_wdata), 32'd0);
        check("rst_ready", 32'(upd_ready), 32'd0);
        check("rst_busy", 32'(init_busy), 32'd1);
        check("rst_occ", 32'(occupancy), 32'd0);
        push_init();
        rst_n = 1'b1;
        run_init(1'b1);

        // Single update saturating at 3, written the next cycle.
        offer(32'h104, 10'h001, 1'b1, 2'd3, 1'b0);
        check("occ_one", 32'(occupancy), 32'd1);
        check("we_next", 32'(pht_we), 32'd1);
        drain();

        // Fill under stall; fifth update is held until space frees.
        pht_wr_stall = 1'b1;
        for (int i = 0; i < 4; i++) offer(32'h200 + 32'(i * 4), 10'h000, i[0], 2'(i), 1'b0);
        upd_valid = 1'b1;
        upd_pc = 32'h300;
        upd_ghr = 10'h011;
        upd_taken = 1'b1;
        upd_prev_ctr = 2'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("full_ready", 32'(upd_ready), 32'(sb.size() < QD));
            check("full_occ", 32'(occupancy), sb.size());
            tick();
        end
        pht_wr_stall = 1'b0;
        offer(32'h300, 10'h011, 1'b1, 2'd0, 1'b0);
        drain();

        // Same index twice: accumulates only with forwarding.
        pht_wr_stall = 1'b1;
        offer(32'h080, 10'h000, 1'b1, 2'd1, 1'b0);
        offer(32'h080, 10'h000, 1'b1, 2'd1, 1'b0);
        drain();
        pht_wr_stall = 1'b1;
        offer(32'h080, 10'h000, 1'b0, 2'd0, 1'b0);
        offer(32'h080, 10'h000, 1'b0, 2'd0, 1'b0);
        drain();

        // Random traffic over a few colliding indices with random stalls.
        for (int i = 0; i < 60; i++) begin
            pht_wr_stall = ($urandom_range(0, 2) == 0);
            offer($urandom & 32'hFFFF_F03F, 10'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1);
        end
        drain();

        // Asynchronous reset with entries queued; they must never be written.
        pht_wr_stall = 1'b1;
        offer(32'h044, 10'h000, 1'b1, 2'd1, 1'b0);
        offer(32'h048, 10'h000, 1'b1, 2'd1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_we", 32'(pht_we), 32'd0);
        check("async_occ", 32'(occupancy), 32'd0);
        check("async_busy", 32'(init_busy), 32'd1);
        check("async_ready", 32'(upd_ready), 32'd0);
        sb.delete();
        pht_wr_stall = 1'b0;
        tick();
        tick();
        push_init();
        rst_n = 1'b1;
        run_init(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
